// File: rtl/scalar_alu_arbiter.sv
// Round-robin arbiter that shares one combinational scalar ALU among NREQ issue slots.
// The granted slot drives the ALU; its result and flags go into one response register tagged with the slot id.
module scalar_alu_arbiter #(
  parameter  int NREQ   = 4,
  parameter  int WORD_W = 32,
  parameter  int OP_W   = 4,
  localparam int ID_W   = $clog2(NREQ)
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*OP_W-1:0]   req_op,
  input  logic [NREQ*WORD_W-1:0] req_porta,
  input  logic [NREQ*WORD_W-1:0] req_portb,
  output logic [OP_W-1:0]        alu_op,
  output logic [WORD_W-1:0]      alu_porta,
  output logic [WORD_W-1:0]      alu_portb,
  input  logic [WORD_W-1:0]      alu_out,
  input  logic                   alu_of,
  input  logic                   alu_zf,
  input  logic                   alu_nf,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WORD_W-1:0]      rsp_out,
  output logic                   rsp_of,
  output logic                   rsp_zf,
  output logic                   rsp_nf
);

  localparam int PW = ID_W + 1;

  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [WORD_W-1:0] rsp_out_q, rsp_out_d;
  logic              rsp_of_q, rsp_of_d;
  logic              rsp_zf_q, rsp_zf_d;
  logic              rsp_nf_q, rsp_nf_d;

  logic              issue_en;
  logic              gnt_found;
  logic [ID_W-1:0]   gnt_id;
  logic [PW-1:0]     idx;

  // Search order starts at rr_ptr and wraps at NREQ-1; one extra bit keeps
  // ptr+k from overflowing before the wrap subtraction.
  always_comb begin
    issue_en  = ~rsp_valid_q | rsp_ready;
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    if (issue_en) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = {1'b0, rr_ptr_q} + PW'(k);
        if (idx >= PW'(NREQ)) idx = idx - PW'(NREQ);
        if (!gnt_found && req_valid[idx[ID_W-1:0]]) begin
          gnt_found = 1'b1;
          gnt_id    = idx[ID_W-1:0];
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    alu_op    = '0;
    alu_porta = '0;
    alu_portb = '0;
    if (gnt_found) begin
      req_ready[gnt_id] = 1'b1;
      alu_op    = req_op[int'(gnt_id)*OP_W +: OP_W];
      alu_porta = req_porta[int'(gnt_id)*WORD_W +: WORD_W];
      alu_portb = req_portb[int'(gnt_id)*WORD_W +: WORD_W];
    end
  end

  // A grant always implies a transfer: only valid slots are granted, and only when issue_en.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_out_d   = rsp_out_q;
    rsp_of_d    = rsp_of_q;
    rsp_zf_d    = rsp_zf_q;
    rsp_nf_d    = rsp_nf_q;
    if (gnt_found) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_id;
      rsp_out_d   = alu_out;
      rsp_of_d    = alu_of;
      rsp_zf_d    = alu_zf;
      rsp_nf_d    = alu_nf;
      rr_ptr_d    = (gnt_id == ID_W'(NREQ-1)) ? '0 : gnt_id + ID_W'(1);
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_out_q   <= '0;
      rsp_of_q    <= 1'b0;
      rsp_zf_q    <= 1'b0;
      rsp_nf_q    <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_out_q   <= rsp_out_d;
      rsp_of_q    <= rsp_of_d;
      rsp_zf_q    <= rsp_zf_d;
      rsp_nf_q    <= rsp_nf_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_of    = rsp_of_q;
  assign rsp_zf    = rsp_zf_q;
  assign rsp_nf    = rsp_nf_q;

endmodule
